pattern_search_engine: RTL

Responder side of the pattern-search request interface. Accepts a search command (pattern address/length, block base/length, `activate`), walks block memory with a naive byte-by-byte compare against pattern memory, and returns `done`/`found` to the requesting top level. Supports resuming after a match so successive `activate` pulses enumerate every occurrence in the window. Sits between the top-level command/display logic and two synchronous-read BRAMs (pattern BRAM and data BRAM).

---
 rtl/pattern_search_engine.sv | 255 +++++++++++++++++++++++++
 1 files changed

// File: rtl/pattern_search_engine.sv
`default_nettype none
// ============================================================================
// Module      : pattern_search_engine
// Description : Responder for pattern-search requests. Walks a window of the
//               data BRAM and compares it byte by byte against a pattern held
//               in the pattern BRAM. Reports done/found. Resuming from a match
//               enumerates later occurrences in the same window.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   CLK100MHZ  in   system clock, rising edge
//   reset      in   synchronous active-high reset, clears all outputs
//   p          in   pattern start address (pattern BRAM)
//   pl         in   pattern length in bytes
//   b          in   block number, window base = {b, 8'h00}
//   bl         in   window length in bytes
//   activate   in   start (IDLE/NOMATCH) or resume (MATCH), one-cycle level
//   restart    in   synchronous abort to IDLE, only busy is cleared
//   pat_addr   out  pattern BRAM read address (registered)
//   pat_data   in   pattern BRAM read data, one cycle after pat_addr
//   mem_addr   out  data BRAM read address (registered)
//   mem_data   in   data BRAM read data, one cycle after mem_addr
//   busy       out  high while comparing (FETCH/CMP)
//   done       out  search finished (MATCH or NOMATCH)
//   found      out  absolute address of the match, all ones when none
//   cycles     out  search duration counter
// Configuration
//   PSA_CYCLE_COUNT_EN : when defined, builds the saturating duration counter;
//                        otherwise cycles is tied to zero.
// ============================================================================
module pattern_search_engine #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
) (
  input  logic              CLK100MHZ,
  input  logic              reset,
  input  logic [7:0]        p,
  input  logic [7:0]        pl,
  input  logic [7:0]        b,
  input  logic [ADDR_W-1:0] bl,
  input  logic              activate,
  input  logic              restart,
  output logic [7:0]        pat_addr,
  input  logic [DATA_W-1:0] pat_data,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] found,
  output logic [ADDR_W-1:0] cycles
);

  localparam int EXT_W = ADDR_W + 1;

  localparam logic [2:0] c_IDLE    = 3'd0;
  localparam logic [2:0] c_FETCH   = 3'd1;
  localparam logic [2:0] c_CMP     = 3'd2;
  localparam logic [2:0] c_MATCH   = 3'd3;
  localparam logic [2:0] c_NOMATCH = 3'd4;

  // One past the highest addressable byte, in the extended width.
  localparam logic [EXT_W-1:0] c_SPAN = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W-1:0] c_NONE = {ADDR_W{1'b1}};

  logic [2:0]        r_state;
  logic [2:0]        w_state_nxt;

  logic [7:0]        r_p;
  logic [7:0]        r_pl;
  logic [ADDR_W-1:0] r_base;
  logic [ADDR_W-1:0] r_bl;
  logic [EXT_W-1:0]  r_s;
  logic [7:0]        r_j;
  logic              r_done;
  logic [ADDR_W-1:0] r_found;
  logic [7:0]        r_pat_addr;
  logic [ADDR_W-1:0] r_mem_addr;

  logic [ADDR_W-1:0] w_base_in;
  logic [EXT_W-1:0]  w_end_in;
  logic              w_guard_in;
  logic [EXT_W-1:0]  w_last;
  logic [EXT_W-1:0]  w_s_next;
  logic [EXT_W-1:0]  w_resume_s;
  logic [7:0]        w_j_next;
  logic              w_eq;
  logic              w_last_byte;
  logic              w_fresh;
  logic              w_resume;
  logic              w_settle;

  assign w_base_in  = ADDR_W'({b, 8'h00});
  assign w_end_in   = {1'b0, w_base_in} + {1'b0, bl};
  // Degenerate requests never enter the compare loop.
  assign w_guard_in = (pl == 8'd0) || (bl < ADDR_W'(pl)) || (w_end_in > c_SPAN);

  // Last legal start position; bl >= pl is guaranteed once latched.
  assign w_last     = {1'b0, r_base} + {1'b0, r_bl} - EXT_W'(r_pl);
  assign w_s_next   = r_s + EXT_W'(1);
  assign w_resume_s = {1'b0, r_found} + EXT_W'(1);
  assign w_j_next   = r_j + 8'd1;
  assign w_eq       = (mem_data == pat_data);
  assign w_last_byte = (r_j == r_pl - 8'd1);

  // A finished search only accepts a new command once done is visible.
  assign w_fresh  = activate && ((r_state == c_IDLE) ||
                                 ((r_state == c_NOMATCH) && r_done));
  assign w_resume = activate && (r_state == c_MATCH) && r_done;

  // done/found are published one edge after the FSM reaches a final state.
  assign w_settle = ((r_state == c_MATCH) || (r_state == c_NOMATCH)) && !r_done;

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_IDLE, c_NOMATCH: begin
        if (w_fresh) begin
          w_state_nxt = w_guard_in ? c_NOMATCH : c_FETCH;
        end
      end
      c_FETCH: w_state_nxt = c_CMP;
      c_CMP: begin
        if (w_eq) begin
          w_state_nxt = w_last_byte ? c_MATCH : c_FETCH;
        end else begin
          w_state_nxt = (w_s_next <= w_last) ? c_FETCH : c_NOMATCH;
        end
      end
      c_MATCH: begin
        if (w_resume) begin
          w_state_nxt = (w_resume_s > w_last) ? c_NOMATCH : c_FETCH;
        end
      end
      default: w_state_nxt = c_IDLE;
    endcase
    if (restart) begin
      w_state_nxt = c_IDLE;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: outputs
  // --------------------------------------------------------------------------
  always_comb begin
    busy = 1'b0;
    if ((r_state == c_FETCH) || (r_state == c_CMP)) begin
      busy = 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Datapath. Addresses are loaded on the edge that enters FETCH so the BRAM
  // registers them at the end of FETCH and the data is ready during CMP.
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      r_p        <= 8'd0;
      r_pl       <= 8'd0;
      r_base     <= '0;
      r_bl       <= '0;
      r_s        <= '0;
      r_j        <= 8'd0;
      r_done     <= 1'b0;
      r_found    <= c_NONE;
      r_pat_addr <= 8'd0;
      r_mem_addr <= '0;
    end else if (restart) begin
      r_j <= 8'd0;
    end else if (w_fresh) begin
      r_p        <= p;
      r_pl       <= pl;
      r_base     <= w_base_in;
      r_bl       <= bl;
      r_s        <= {1'b0, w_base_in};
      r_j        <= 8'd0;
      r_done     <= 1'b0;
      r_found    <= c_NONE;
      r_mem_addr <= w_base_in;
      r_pat_addr <= p;
    end else if (w_resume) begin
      r_s        <= w_resume_s;
      r_j        <= 8'd0;
      r_done     <= 1'b0;
      r_mem_addr <= w_resume_s[ADDR_W-1:0];
      r_pat_addr <= r_p;
    end else if (r_state == c_CMP) begin
      if (w_eq) begin
        if (!w_last_byte) begin
          r_j        <= w_j_next;
          r_mem_addr <= r_s[ADDR_W-1:0] + ADDR_W'(w_j_next);
          r_pat_addr <= r_p + w_j_next;
        end
      end else begin
        r_s        <= w_s_next;
        r_j        <= 8'd0;
        r_mem_addr <= w_s_next[ADDR_W-1:0];
        r_pat_addr <= r_p;
      end
    end else if (w_settle) begin
      r_done  <= 1'b1;
      r_found <= (r_state == c_MATCH) ? r_s[ADDR_W-1:0] : c_NONE;
    end
  end

  assign pat_addr = r_pat_addr;
  assign mem_addr = r_mem_addr;
  assign done     = r_done;
  assign found    = r_found;

`ifdef PSA_CYCLE_COUNT_EN
  // Counts every edge from command acceptance up to and including the edge
  // that raises done, then holds.
  logic [ADDR_W-1:0] r_cycles;
  logic              r_cnt_run;

  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      r_cycles  <= '0;
      r_cnt_run <= 1'b0;
    end else if (restart) begin
      r_cnt_run <= 1'b0;
    end else if (w_fresh || w_resume) begin
      r_cycles  <= '0;
      r_cnt_run <= 1'b1;
    end else if (r_cnt_run) begin
      if (r_cycles != c_NONE) begin
        r_cycles <= r_cycles + ADDR_W'(1);
      end
      if (w_settle) begin
        r_cnt_run <= 1'b0;
      end
    end
  end

  assign cycles = r_cycles;
`else
  assign cycles = '0;
`endif

endmodule
`default_nettype wire
